line_follow_ctrl: RTL

- Clocked, parametrised successor of the combinational motion-logic block for the line-follower car.
- Synchronises and debounces an N-wide reflective sensor bar, then runs a steering state machine.
- Searches toward the last-seen line side, with a timeout, and counts laps on debounced finish-marker edges.
- Applies per-circuit stop rules. Drives direction codes and duty-compare words for the two PWM comparators, plus indicator outputs.

---
 rtl/line_follow_ctrl_if.sv | 29 ++
 rtl/line_follow_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl_if.sv
// Sensor/mode inputs and motor-drive outputs of the line-follower controller.
interface line_follow_ctrl_if #(
  parameter int N_SENS = 5,
  parameter int DUTY_W = 12,
  parameter int LAP_W  = 8
);
  logic [N_SENS-1:0] sensors;
  logic [1:0]        circuit;
  logic [1:0]        directie_driverA;
  logic [1:0]        directie_driverB;
  logic [DUTY_W-1:0] factor_dc_driverA;
  logic [DUTY_W-1:0] factor_dc_driverB;
  logic              semnal_stanga;
  logic              semnal_dreapta;
  logic              stop;
  logic [LAP_W-1:0]  count_ture;
  logic [2:0]        state_dbg;

  modport slave (
    input  sensors, circuit,
    output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
           semnal_stanga, semnal_dreapta, stop, count_ture, state_dbg
  );
  modport master (
    output sensors, circuit,
    input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
           semnal_stanga, semnal_dreapta, stop, count_ture, state_dbg
  );
endinterface

// File: rtl/line_follow_ctrl.sv
// Line-follower controller: sensor sync/debounce, steering FSM, lap counting,
// registered motor direction/duty and indicator outputs.
module line_follow_ctrl #(
  parameter int                 N_SENS     = 5,
  parameter int                 DUTY_W     = 12,
  parameter logic [DUTY_W-1:0]  DUTY_MAX   = 12'h999,
  parameter logic [DUTY_W-1:0]  DUTY_TURN  = 12'h400,
  parameter int                 DEB_CYC    = 4,
  parameter int                 LOST_TMO   = 50000,
  parameter int                 LAP_W      = 8,
  parameter int                 LAP_TARGET = 10
) (
  input logic              clk,
  input logic              rst,
  line_follow_ctrl_if.slave bus
);
  localparam int C  = (N_SENS - 1) / 2;
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TW = (LOST_TMO > 1) ? $clog2(LOST_TMO) : 1;
  localparam logic [1:0] FWD = 2'b10, REV = 2'b01, OFF = 2'b00;

  typedef enum logic [2:0] {
    IDLE = 3'd0, FOLLOW = 3'd1, SEARCH = 3'd2, LOST = 3'd3, FINISH = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [N_SENS-1:0] sync1, sync2, deb;
  logic              last_side, last_nx, fin_q;
  logic [TW-1:0]     timer, timer_nx;
  logic [LAP_W-1:0]  count, count_nx, cnt_inc;
  logic              lap_hit;

  logic [1:0]        dir_a, dir_b, dir_a_nx, dir_b_nx;
  logic [DUTY_W-1:0] duty_a, duty_b, duty_a_nx, duty_b_nx;
  logic              sl, sr, stp, sl_nx, sr_nx, stp_nx;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sensors;
      sync2 <= sync1;
    end

  // A bit flips only after DEB_CYC consecutive differing samples.
  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          bit_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt   <= '0;
        bit_q <= 1'b0;
      end else if (sync2[i] == bit_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        cnt   <= '0;
        bit_q <= sync2[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign deb[i] = bit_q;
  end

  logic l_t, r_t, m_t, on_line, fin, lap_rise;
  assign l_t      = |deb[C-1:1];
  assign r_t      = |deb[N_SENS-2:C+1];
  assign m_t      = deb[C];
  assign on_line  = l_t | r_t | m_t;
  assign fin      = deb[0] & deb[N_SENS-1];
  assign lap_rise = fin & ~fin_q;
  assign cnt_inc  = (&count) ? count : count + LAP_W'(1);

  always_comb begin
    state_nx = state;
    last_nx  = last_side;
    timer_nx = timer;
    count_nx = count;
    lap_hit  = 1'b0;
    if (bus.circuit == 2'b00) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        IDLE: state_nx = FOLLOW;
        FOLLOW, SEARCH: begin
          // Lap is counted before the line-loss decision of the same cycle.
          if (lap_rise) begin
            count_nx = cnt_inc;
            lap_hit  = (bus.circuit == 2'b01 && cnt_inc == LAP_W'(1)) ||
                       (bus.circuit == 2'b10 && cnt_inc == LAP_W'(LAP_TARGET));
          end
          if (lap_hit) begin
            state_nx = FINISH;
          end else if (state == FOLLOW) begin
            if (!on_line) begin
              state_nx = SEARCH;
              timer_nx = '0;
            end else if (l_t && !r_t) begin
              last_nx = 1'b0;
            end else if (r_t && !l_t) begin
              last_nx = 1'b1;
            end
          end else begin
            if (on_line)                          state_nx = FOLLOW;
            else if (timer == TW'(LOST_TMO - 1)) state_nx = LOST;
            else                                  timer_nx = timer + 1'b1;
          end
        end
        LOST:    if (on_line) state_nx = FOLLOW;
        FINISH:  state_nx = FINISH;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with state_dbg.
  always_comb begin
    dir_a_nx  = OFF;
    dir_b_nx  = OFF;
    duty_a_nx = '0;
    duty_b_nx = '0;
    stp_nx    = 1'b1;
    sl_nx     = deb[0];
    sr_nx     = deb[N_SENS-1];
    case (state_nx)
      IDLE: begin
        sl_nx = 1'b0;
        sr_nx = 1'b0;
      end
      FOLLOW: begin
        stp_nx    = 1'b0;
        dir_a_nx  = FWD;
        dir_b_nx  = FWD;
        duty_a_nx = (l_t && !r_t) ? DUTY_TURN : DUTY_MAX;
        duty_b_nx = (r_t && !l_t) ? DUTY_TURN : DUTY_MAX;
      end
      SEARCH: begin
        dir_a_nx  = last_nx ? FWD : REV;
        dir_b_nx  = last_nx ? REV : FWD;
        duty_a_nx = DUTY_TURN;
        duty_b_nx = DUTY_TURN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      last_side <= 1'b0;
      timer     <= '0;
      count     <= '0;
      fin_q     <= 1'b0;
      dir_a     <= OFF;
      dir_b     <= OFF;
      duty_a    <= '0;
      duty_b    <= '0;
      sl        <= 1'b0;
      sr        <= 1'b0;
      stp       <= 1'b1;
    end else begin
      state     <= state_nx;
      last_side <= last_nx;
      timer     <= timer_nx;
      count     <= count_nx;
      fin_q     <= fin;
      dir_a     <= dir_a_nx;
      dir_b     <= dir_b_nx;
      duty_a    <= duty_a_nx;
      duty_b    <= duty_b_nx;
      sl        <= sl_nx;
      sr        <= sr_nx;
      stp       <= stp_nx;
    end

  assign bus.directie_driverA  = dir_a;
  assign bus.directie_driverB  = dir_b;
  assign bus.factor_dc_driverA = duty_a;
  assign bus.factor_dc_driverB = duty_b;
  assign bus.semnal_stanga     = sl;
  assign bus.semnal_dreapta    = sr;
  assign bus.stop              = stp;
  assign bus.count_ture        = count;
  assign bus.state_dbg         = state;
endmodule
